// File: rtl/gj_axis_uart_tx_mc_if.sv
// AXI-Stream character channel feeding the UART transmitter.
interface gj_axis_uart_tx_mc_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/gj_axis_uart_tx_mc.sv
// UART transmitter with AXIS input FIFO, per-frame latched configuration,
// optional parity, 1/2 stop bits, post-packet idle gap and line break.
module gj_axis_uart_tx_mc #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            baud_div_i,
  input  logic                        cfg_stop2_i,
  input  logic                        cfg_par_en_i,
  input  logic                        cfg_par_odd_i,
  input  logic                        cfg_msb_first_i,
  input  logic                        cfg_gap_en_i,
  input  logic [15:0]                 cfg_gap_i,
  input  logic                        tx_break_i,
  gj_axis_uart_tx_mc_if.slave         tx_axis,
  output logic                        tx_o,
  output logic                        tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [3:0]  LastBit = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StGap, StBreak
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              push, pop;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  assign tx_axis.tready     = (level_q != LW'(FIFO_DEPTH));
  assign push               = tx_axis.tvalid && tx_axis.tready;
  assign {rd_last, rd_data} = mem_q[rd_ptr_q];

  // Storage array, written on every accepted beat.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tx_axis.tlast, tx_axis.tdata};
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       gap_q, gap_d;
  logic [15:0]       gap_len_q, gap_len_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              tlast_q, tlast_d;
  logic              stop2_q, stop2_d;
  logic              par_en_q, par_en_d;
  logic              gap_en_q, gap_en_d;
  logic              brk_rel_q, brk_rel_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W); i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  assign bit_end = (baud_q == div_q);

  // Next-state, counters, per-frame latches and the next line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    gap_len_d = gap_len_q;
    sh_d      = sh_q;
    par_d     = par_q;
    tlast_d   = tlast_q;
    stop2_d   = stop2_q;
    par_en_d  = par_en_q;
    gap_en_d  = gap_en_q;
    brk_rel_d = brk_rel_q;
    pop       = 1'b0;

    if (state_q != StIdle) baud_d = bit_end ? '0 : baud_q + DIV_W'(1);

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        cnt_d  = '0;
        gap_d  = '0;
        // Break wins over a pending character; nothing is popped while breaking.
        if (tx_break_i) begin
          state_d   = StBreak;
          brk_rel_d = 1'b0;
          div_d     = baud_div_i;
        end else if (level_q != '0) begin
          pop       = 1'b1;
          state_d   = StStart;
          div_d     = baud_div_i;
          // Bit order is folded into the shift register so DATA always emits bit 0.
          sh_d      = cfg_msb_first_i ? bit_rev(rd_data) : rd_data;
          par_d     = (^rd_data) ^ cfg_par_odd_i;
          tlast_d   = rd_last;
          stop2_d   = cfg_stop2_i;
          par_en_d  = cfg_par_en_i;
          gap_en_d  = cfg_gap_en_i;
          gap_len_d = cfg_gap_i;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (cnt_q == LastBit) begin
            state_d = par_en_q ? StParity : StStop;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
            sh_d  = sh_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && (cnt_q == '0)) begin
            cnt_d = 4'd1;
          end else if (tlast_q && gap_en_q && (gap_len_q != '0)) begin
            state_d = StGap;
            gap_d   = gap_len_q - 16'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        // gap_q holds the number of bit periods still to go after the current one.
        if (bit_end) begin
          if (gap_q == '0) state_d = StIdle;
          else             gap_d   = gap_q - 16'd1;
        end
      end
      StBreak: begin
        if (!brk_rel_q) begin
          baud_d = '0;
          if (!tx_break_i) begin
            brk_rel_d = 1'b1;
            cnt_d     = '0;
          end
        end else if (bit_end) begin
          if (cnt_q != '0) state_d = StIdle;
          else             cnt_d   = 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from the next state so tx changes on the transition edge.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = sh_d[0];
      StParity: tx_d = par_d;
      StBreak:  tx_d = brk_rel_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // FSM and datapath state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      gap_len_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      tlast_q   <= 1'b0;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      gap_en_q  <= 1'b0;
      brk_rel_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      gap_len_q <= gap_len_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      tlast_q   <= tlast_d;
      stop2_q   <= stop2_d;
      par_en_q  <= par_en_d;
      gap_en_q  <= gap_en_d;
      brk_rel_q <= brk_rel_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign tx_busy_o    = (state_q != StIdle);
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_gj_axis_uart_tx_mc.sv
// Self-checking bench for gj_axis_uart_tx_mc: table vectors, randomized frames
// against a bit-list reference model, and hand-written corner sequences.
module tb_gj_axis_uart_tx_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        cfg_stop2, cfg_par_en, cfg_par_odd, cfg_msb_first, cfg_gap_en;
  logic [15:0] cfg_gap;
  logic        tx_break;
  logic        tx, tx_busy;
  logic [4:0]  fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_bits[$];

  gj_axis_uart_tx_mc_if #(.DATA_W(8)) axis ();

  gj_axis_uart_tx_mc #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_div_i     (baud_div),
    .cfg_stop2_i    (cfg_stop2),
    .cfg_par_en_i   (cfg_par_en),
    .cfg_par_odd_i  (cfg_par_odd),
    .cfg_msb_first_i(cfg_msb_first),
    .cfg_gap_en_i   (cfg_gap_en),
    .cfg_gap_i      (cfg_gap),
    .tx_break_i     (tx_break),
    .tx_axis        (axis.slave),
    .tx_o           (tx),
    .tx_busy_o      (tx_busy),
    .fifo_level_o   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         pe, po, s2, msb;
    int         div;
    bit         exp_par;
    int         exp_nbits;
  } vec_t;

  typedef struct {
    bit last;
    int gap;
    int exp_wait;
  } gap_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit po, input bit s2,
                         input bit msb, input bit ge, input int gap);
    baud_div      = 16'(div);
    cfg_par_en    = pe;
    cfg_par_odd   = po;
    cfg_stop2     = s2;
    cfg_msb_first = msb;
    cfg_gap_en    = ge;
    cfg_gap       = 16'(gap);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_beat(input logic [7:0] d, input bit last);
    int t;
    t = 0;
    axis.tdata  = d;
    axis.tlast  = last;
    axis.tvalid = 1'b1;
    while (!axis.tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!axis.tready) chk("push accepted", 0, 1);
    @(negedge clk);
    axis.tvalid = 1'b0;
  endtask

  // Counts negedges until tx is sampled low (0 if already low).
  task automatic wait_low(input int limit, input string tag, output int n);
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) chk({tag, " start bit seen"}, 0, 1);
  endtask

  // Reference model: line level for each bit period of one frame.
  task automatic build_frame(input logic [7:0] d, input bit pe, input bit po,
                             input bit s2, input bit msb);
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(msb ? d[7-i] : d[i]);
    if (pe) exp_bits.push_back((($countones(d) % 2) == 1) ^ po);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  // Starts on the first sampled cycle of the start bit; ends on the last stop cycle.
  task automatic check_frame(input string tag, input int div, input bit scramble);
    int bad;
    for (int b = 0; b < exp_bits.size(); b++) begin
      bad = 0;
      for (int c = 0; c <= div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (tx !== exp_bits[b]) bad++;
        if (scramble && b == 0 && c == 0)
          set_cfg($urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
      chk($sformatf("%s bit%0d bad cycles", tag, b), bad, 0);
    end
    chk({tag, " busy on last stop"}, int'(tx_busy), 1);
  endtask

  vec_t     vecs[7];
  gap_vec_t gvecs[3];
  logic [7:0] burst[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, lows, div;
    bit pe, po, s2, msb;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 10};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b1, 12};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 12};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 11};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 12};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 11};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0, 11};

    gvecs[0] = '{1'b1, 5, 12};
    gvecs[1] = '{1'b0, 5, 2};
    gvecs[2] = '{1'b1, 0, 2};

    rst         = 1'b1;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;
    tx_break    = 1'b0;
    set_cfg(3, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(tx_busy), 0);
    chk("reset level", int'(fifo_level), 0);
    chk("reset tready", int'(axis.tready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: latency, every bit period, then back to idle.
    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].div, vecs[i].pe, vecs[i].po, vecs[i].s2, vecs[i].msb, 0, 0);
      push_beat(vecs[i].data, 1'b0);
      wait_low(50, $sformatf("v%0d", i), n);
      chk($sformatf("v%0d start latency", i), n, 1);
      exp_bits = {};
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++)
        exp_bits.push_back(vecs[i].msb ? vecs[i].data[7-j] : vecs[i].data[j]);
      if (vecs[i].pe) exp_bits.push_back(vecs[i].exp_par);
      while (exp_bits.size() < vecs[i].exp_nbits) exp_bits.push_back(1'b1);
      check_frame($sformatf("v%0d", i), vecs[i].div, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d idle busy", i), int'(tx_busy), 0);
      chk($sformatf("v%0d idle tx", i), int'(tx), 1);
    end

    // Random single frames; configuration is scrambled mid-frame.
    for (int r = 0; r < 24; r++) begin
      div = $urandom_range(0, 4);
      pe  = 1'($urandom);
      po  = 1'($urandom);
      s2  = 1'($urandom);
      msb = 1'($urandom);
      d   = 8'($urandom);
      set_cfg(div, pe, po, s2, msb, 0, 0);
      push_beat(d, 1'($urandom));
      wait_low(50, $sformatf("r%0d", r), n);
      chk($sformatf("r%0d start latency", r), n, 1);
      build_frame(d, pe, po, s2, msb);
      check_frame($sformatf("r%0d d=%02h", r, d), div, 1'b1);
      @(negedge clk);
      chk($sformatf("r%0d idle busy", r), int'(tx_busy), 0);
    end

    // 17 beats into a 16-deep FIFO while busy.
    set_cfg(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) burst[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 17; i++) push_beat(burst[i], 1'b0);
        chk("burst level full", int'(fifo_level), 16);
        chk("burst tready low", int'(axis.tready), 0);
      end
      begin
        int m;
        for (int i = 0; i < 17; i++) begin
          wait_low((i == 0) ? 50 : 5, $sformatf("b%0d", i), m);
          if (i > 0) chk($sformatf("b%0d inter-frame cycles", i), m, 2);
          build_frame(burst[i], 0, 0, 0, 0);
          check_frame($sformatf("b%0d", i), 1, 1'b0);
        end
      end
    join
    @(negedge clk);
    chk("burst drained level", int'(fifo_level), 0);

    // Post-packet gap with a queued follower.
    for (int g = 0; g < 3; g++) begin
      set_cfg(1, 0, 0, 0, 0, 1, gvecs[g].gap);
      push_beat(8'hC3, gvecs[g].last);
      push_beat(8'h5A, 1'b0);
      wait_low(50, $sformatf("g%0d", g), n);
      build_frame(8'hC3, 0, 0, 0, 0);
      check_frame($sformatf("g%0d first", g), 1, 1'b0);
      wait_low(100, $sformatf("g%0d second", g), n);
      chk($sformatf("g%0d stop-to-start cycles", g), n, gvecs[g].exp_wait);
      build_frame(8'h5A, 0, 0, 0, 0);
      check_frame($sformatf("g%0d second", g), 1, 1'b0);
      @(negedge clk);
    end

    // Break requested during the data bits of 0x55.
    set_cfg(2, 0, 0, 0, 0, 0, 0);
    push_beat(8'h55, 1'b0);
    fork
      begin
        int m;
        wait_low(20, "brk", m);
        build_frame(8'h55, 0, 0, 0, 0);
        check_frame("brk frame", 2, 1'b0);
        @(negedge clk);
        chk("brk idle cycle tx", int'(tx), 1);
        lows = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (tx !== 1'b0) lows++;
        end
        chk("brk held-low high cycles", lows, 0);
        chk("brk busy", int'(tx_busy), 1);
        chk("brk no pop level", int'(fifo_level), 1);
      end
      begin
        repeat (12) @(negedge clk);
        tx_break = 1'b1;
        push_beat(8'h3A, 1'b0);
      end
    join
    tx_break = 1'b0;
    @(negedge clk);
    wait_low(100, "post-brk", n);
    chk("brk release to start cycles", n, 7);
    build_frame(8'h3A, 0, 0, 0, 0);
    check_frame("post-brk", 2, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of a frame with 3 entries queued.
    set_cfg(3, 0, 0, 0, 0, 0, 0);
    push_beat(8'h00, 1'b0);
    push_beat(8'hB2, 1'b0);
    push_beat(8'hC3, 1'b0);
    push_beat(8'hD4, 1'b0);
    chk("rst pre level", int'(fifo_level), 3);
    repeat (10) @(negedge clk);
    chk("rst pre tx low in data", int'(tx), 0);
    #1 rst = 1'b1;
    #1;
    chk("rst async tx", int'(tx), 1);
    chk("rst async level", int'(fifo_level), 0);
    chk("rst async busy", int'(tx_busy), 0);
    chk("rst async tready", int'(axis.tready), 1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst no further frames", lows, 0);
    set_cfg(3, 0, 0, 0, 0, 0, 0);
    push_beat(8'h96, 1'b0);
    wait_low(50, "after rst", n);
    chk("after rst start latency", n, 1);
    build_frame(8'h96, 0, 0, 0, 0);
    check_frame("after rst", 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gj_axis_uart_tx_mc.md
GJ_AXIS_UART_TX_MC -- requirements
Module: gj_axis_uart_tx_mc

Interface
REQ-001 Parameter DATA_W, default 8, meaning data bits per frame, legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning input FIFO entries, power of 2, at least 2.
REQ-003 Parameter DIV_W, default 16, meaning baud divider width.
REQ-004 Port clk, input, 1, meaning the single clock for all logic.
REQ-005 Port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 Port baud_div, input, DIV_W, meaning bit period of baud_div+1 clk cycles.
REQ-007 Port cfg_stop2, input, 1, meaning 0 gives 1 stop bit and 1 gives 2 stop bits.
REQ-008 Port cfg_par_en, input, 1, meaning a parity bit is appended.
REQ-009 Port cfg_par_odd, input, 1, meaning 0 selects even parity and 1 selects odd parity.
REQ-010 Port cfg_msb_first, input, 1, meaning 0 sends LSB first and 1 sends MSB first.
REQ-011 Port cfg_gap_en, input, 1, meaning an idle gap is inserted after a tlast frame.
REQ-012 Port cfg_gap, input, 16, meaning the gap length in bit periods.
REQ-013 Port tx_break, input, 1, meaning a request to hold the line low.
REQ-014 Port tx_tvalid, input, 1, meaning the AXIS beat is valid.
REQ-015 Port tx_tready, output, 1, meaning the FIFO is not full.
REQ-016 Port tx_tdata, input, DATA_W, meaning the character to send.
REQ-017 Port tx_tlast, input, 1, meaning the beat ends a packet.
REQ-018 Port tx, output, 1, meaning the registered serial line, idle high.
REQ-019 Port tx_busy, output, 1, meaning the FSM is not in IDLE.
REQ-020 Port fifo_level, output, log2(FIFO_DEPTH)+1, meaning the current FIFO occupancy.

Function
REQ-021 The block SHALL accept a beat whenever tx_tvalid and tx_tready are both high, storing {tlast, tdata} in the FIFO.
REQ-022 tx_tready SHALL equal (fifo_level != FIFO_DEPTH) and SHALL NOT depend combinationally on tx_tvalid.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, GAP and BREAK.
REQ-025 In IDLE, with tx_break low and the FIFO non-empty, the FSM SHALL pop one entry, latch every cfg_* input and baud_div, and enter START.
REQ-026 If a beat is written into an empty FIFO at edge N while the FSM is idle, tx SHALL fall at edge N+1.
REQ-027 Each bit SHALL last exactly baud_div+1 clk cycles; baud_div=0 SHALL give one cycle per bit.
REQ-028 The baud counter SHALL restart at each frame start, so that no partial first bit occurs.
REQ-029 The frame SHALL be 1 start bit (0), then DATA_W data bits in the latched bit order, then an optional parity bit, then 1 or 2 stop bits (1).
REQ-030 Parity SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-031 cfg_* changes during a frame SHALL NOT affect that frame; they SHALL take effect at the next frame start.
REQ-032 At the end of STOP, if the popped entry had tlast set, cfg_gap_en was latched high and cfg_gap is non-zero, the FSM SHALL enter GAP for cfg_gap*(baud_div+1) cycles with tx=1; otherwise the FSM SHALL go to IDLE.
REQ-033 At the end of STOP or GAP, if the FIFO is non-empty, the FSM SHALL pass through IDLE for exactly one cycle and then start the next frame, with no extra idle bit.
REQ-034 tx_break SHALL be honoured only in IDLE: the FSM enters BREAK, tx=0, and no pop occurs.
REQ-035 On tx_break low, the FSM SHALL hold tx=1 for 2 bit periods and then return to IDLE.
REQ-036 If tx_break asserts mid-frame or mid-gap, the current frame or gap SHALL complete before BREAK is entered.
REQ-037 tx_busy SHALL be high in every state except IDLE.

Reset
REQ-038 On rst high, asynchronously: tx=1, tx_busy=0, fifo_level=0, tx_tready=1, FSM=IDLE, and the baud and gap counters cleared.
REQ-039 Reset mid-frame SHALL abort the frame and discard all FIFO contents, and tx SHALL return high immediately.
REQ-040 After rst deasserts, the first accepted beat SHALL start a frame per REQ-026.

Verification
REQ-041 With DATA_W=8, baud_div=3, 1 stop bit, no parity, LSB first, sending 0xA5 SHALL produce tx = 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles, for 40 cycles total.
REQ-042 Sending 0x07 with even parity and 2 stop bits SHALL give parity bit 1 and 12 bit periods; with odd parity, the parity bit SHALL be 0.
REQ-043 Pushing 17 beats with FIFO_DEPTH=16 while tx is busy SHALL drop tx_tready after 16 entries with fifo_level=16, and all 17 bytes SHALL arrive in order back-to-back.
REQ-044 With cfg_gap_en=1, cfg_gap=5 and baud_div=1, a tlast byte followed by a queued byte SHALL leave tx high for 10 gap cycles plus 1 IDLE cycle between its stop bit and the next start bit.
REQ-045 Asserting tx_break during the data bits of 0x55 SHALL finish that frame and then hold tx low until tx_break drops, followed by 2 high bit periods before the next frame.
REQ-046 Asserting rst in the middle of DATA with 3 entries queued SHALL give tx=1 and fifo_level=0 asynchronously, and no further frames SHALL follow.
